led_scanner_pwm: RTL and testbench

LED_SCANNER_PWM -- requirements
Module: led_scanner_pwm

---
 rtl/led_scanner_pwm_pkg.sv | 11 +
 rtl/led_scanner_pwm_if.sv | 28 ++
 rtl/led_scanner_pwm_channel.sv | 44 ++++
 rtl/led_scanner_pwm.sv | 104 ++++++++++
 tb/tb_led_scanner_pwm.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/led_scanner_pwm_pkg.sv
// Shared scan-mode encoding for the LED scanner.
package led_scan_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE    = 2'd0,
    MODE_WRAP_UP   = 2'd1,
    MODE_WRAP_DOWN = 2'd2,
    MODE_HOLD      = 2'd3
  } scan_mode_t;

endpackage

// File: rtl/led_scanner_pwm_if.sv
// Control and LED-drive bundle of the scanner. The scanner is the slave:
// it samples the controls and drives the LED/position/status outputs.
interface led_scanner_pwm_if #(
  parameter int N_LEDS = 26,
  parameter int STEP_W = 24,
  parameter int PWM_W  = 8
);
  import led_scan_pkg::*;

  logic                      enable;
  scan_mode_t                mode;
  logic [STEP_W-1:0]         step_period;
  logic [PWM_W-1:0]          decay_step;
  logic [N_LEDS-1:0]         led;
  logic [$clog2(N_LEDS)-1:0] position;
  logic                      dir;
  logic                      step_pulse;

  modport master (
    output enable, mode, step_period, decay_step,
    input  led, position, dir, step_pulse
  );

  modport slave (
    input  enable, mode, step_period, decay_step,
    output led, position, dir, step_pulse
  );
endinterface

// File: rtl/led_scanner_pwm_channel.sv
// One LED channel. With LED_SCANNER_FADE_EN: brightness register, saturating
// decay and PWM comparator; otherwise a registered select bit.
module led_pwm_channel
`ifdef LED_SCANNER_FADE_EN
#(
  parameter int PWM_W      = 8,
  parameter bit RESET_FULL = 1'b0
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
`ifdef LED_SCANNER_FADE_EN
  input  logic             step,
  input  logic [PWM_W-1:0] decay_step,
  input  logic [PWM_W-1:0] pwm_cnt,
`endif
  output logic             led
);

`ifdef LED_SCANNER_FADE_EN
  localparam logic [PWM_W-1:0] BMAX = '1;

  logic [PWM_W-1:0] b;

  // Full brightness always lights so that BMAX gives a 100% duty cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      b   <= RESET_FULL ? BMAX : '0;
      led <= 1'b0;
    end else begin
      if (step) b <= sel ? BMAX : ((b > decay_step) ? b - decay_step : '0);
      led <= (b == BMAX) || (b > pwm_cnt);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) led <= 1'b0;
    else     led <= sel;
  end
`endif

endmodule

// File: rtl/led_scanner_pwm.sv
// Knight-rider style LED scanner with optional fading trails
// (macro LED_SCANNER_FADE_EN enables brightness/PWM).
module led_scanner_pwm
  import led_scan_pkg::*;
#(
  parameter int N_LEDS = 26,
  parameter int STEP_W = 24,
  parameter int PWM_W  = 8
) (
  input logic             CLOCK_50,
  input logic             RESET,
  led_scanner_pwm_if.slave bus
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] LAST = POS_W'(N_LEDS - 1);

  logic [STEP_W-1:0] cnt;
  logic [POS_W-1:0]  pos_q, pos_nxt;
  logic              dir_q, dir_nxt;
  logic              step, step_pulse_q;
  logic [N_LEDS-1:0] led_w;

  assign step = bus.enable && (cnt == bus.step_period);

  always_comb begin
    pos_nxt = pos_q;
    dir_nxt = dir_q;
    if (step) begin
      unique case (bus.mode)
        MODE_BOUNCE: begin
          if (dir_q && pos_q == LAST) begin
            pos_nxt = POS_W'(N_LEDS - 2);
            dir_nxt = 1'b0;
          end else if (!dir_q && pos_q == '0) begin
            pos_nxt = POS_W'(1);
            dir_nxt = 1'b1;
          end else begin
            pos_nxt = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          end
        end
        MODE_WRAP_UP: begin
          dir_nxt = 1'b1;
          pos_nxt = (pos_q == LAST) ? '0 : pos_q + POS_W'(1);
        end
        MODE_WRAP_DOWN: begin
          dir_nxt = 1'b0;
          pos_nxt = (pos_q == '0) ? LAST : pos_q - POS_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cnt          <= '0;
      pos_q        <= '0;
      dir_q        <= 1'b1;
      step_pulse_q <= 1'b0;
    end else begin
      if (bus.enable) cnt <= step ? '0 : cnt + STEP_W'(1);
      pos_q        <= pos_nxt;
      dir_q        <= dir_nxt;
      step_pulse_q <= step;
    end
  end

`ifdef LED_SCANNER_FADE_EN
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + PWM_W'(1);
  end
`endif

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_pwm_channel
`ifdef LED_SCANNER_FADE_EN
    #(
      .PWM_W     (PWM_W),
      .RESET_FULL(i == 0)
    )
`endif
    u_ch (
      .clk       (CLOCK_50),
      .rst       (RESET),
      .sel       (pos_nxt == POS_W'(i)),
`ifdef LED_SCANNER_FADE_EN
      .step      (step),
      .decay_step(bus.decay_step),
      .pwm_cnt   (pwm_cnt),
`endif
      .led       (led_w[i])
    );
  end

  assign bus.led        = led_w;
  assign bus.position   = pos_q;
  assign bus.dir        = dir_q;
  assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_scanner_pwm.sv
// Randomized scoreboard bench for led_scanner_pwm (N_LEDS=4); follows
// LED_SCANNER_FADE_EN for the expected LED pattern.
module tb_led_scanner_pwm;
  import led_scan_pkg::*;

  localparam int N     = 4;
  localparam int SW    = 8;
  localparam int PW    = 8;
  localparam int BMAX  = 255;
  localparam int POS_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_scanner_pwm_if #(.N_LEDS(N), .STEP_W(SW), .PWM_W(PW)) bus ();

  led_scanner_pwm #(.N_LEDS(N), .STEP_W(SW), .PWM_W(PW)) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic             sp;
    logic             dir;
    logic [POS_W-1:0] pos;
    logic [N-1:0]     led;
  } cyc_t;

  cyc_t             cyc_q[$];
  logic [POS_W:0]   exp_q[$];
  int checks = 0;
  int fails  = 0;

  int m_cnt, m_pos, m_dir, m_pwm;
  int m_b[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic advance(input scan_mode_t m);
    case (m)
      MODE_BOUNCE: begin
        if (m_dir == 1 && m_pos == N - 1) begin m_pos = N - 2; m_dir = 0; end
        else if (m_dir == 0 && m_pos == 0) begin m_pos = 1; m_dir = 1; end
        else m_pos = m_pos + (m_dir == 1 ? 1 : -1);
      end
      MODE_WRAP_UP:   begin m_dir = 1; m_pos = (m_pos + 1) % N; end
      MODE_WRAP_DOWN: begin m_dir = 0; m_pos = (m_pos + N - 1) % N; end
      default: ;
    endcase
  endtask

  // Predict the outcome of the next rising edge, queue it, then cross that edge.
  task automatic tick();
    cyc_t e;
    logic [N-1:0] l;
    bit st;
    int dec;
    st = 0;
    l  = '0;
    if (rst) begin
      m_cnt = 0; m_pos = 0; m_dir = 1; m_pwm = 0;
      for (int i = 0; i < N; i++) m_b[i] = (i == 0) ? BMAX : 0;
    end else begin
      for (int i = 0; i < N; i++) l[i] = (m_b[i] == BMAX) || (m_b[i] > m_pwm);
      m_pwm = (m_pwm + 1) % (BMAX + 1);
      if (bus.enable) begin
        if (m_cnt == int'(bus.step_period)) begin
          st = 1;
          m_cnt = 0;
          advance(bus.mode);
          dec = int'(bus.decay_step);
          for (int i = 0; i < N; i++)
            m_b[i] = (i == m_pos) ? BMAX : ((m_b[i] > dec) ? m_b[i] - dec : 0);
        end else begin
          m_cnt = (m_cnt + 1) % (1 << SW);
        end
      end
`ifndef LED_SCANNER_FADE_EN
      l = '0;
      l[m_pos] = 1'b1;
`endif
    end
    e.sp  = st;
    e.dir = m_dir[0];
    e.pos = POS_W'(m_pos);
    e.led = l;
    cyc_q.push_back(e);
    if (st) exp_q.push_back({m_dir[0], POS_W'(m_pos)});
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set(input bit en, input scan_mode_t m, input int sp, input int dc);
    bus.enable      = en;
    bus.mode        = m;
    bus.step_period = SW'(sp);
    bus.decay_step  = PW'(dc);
  endtask

  always @(negedge clk) begin
    cyc_t e;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      check("step_pulse", 32'(bus.step_pulse), 32'(e.sp));
      check("position",   32'(bus.position),   32'(e.pos));
      check("dir",        32'(bus.dir),        32'(e.dir));
      check("led",        32'(bus.led),        32'(e.led));
    end
  end

  // Step events are matched against the queue of predicted steps.
  always @(negedge clk) begin
    logic [POS_W:0] s;
    if (bus.step_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_step", 32'(1), 32'(0));
      end else begin
        s = exp_q.pop_front();
        check("step_pos_dir", 32'({bus.dir, bus.position}), 32'(s));
      end
    end
  end

  initial begin
    rst = 1'b1;
    set(1'b0, MODE_BOUNCE, 0, 0);
    run(2);
    rst = 1'b0;

    set(1'b1, MODE_BOUNCE, 0, 0);
    run(12);
    set(1'b1, MODE_WRAP_UP, 2, 0);
    run(15);
    set(1'b1, MODE_WRAP_DOWN, 2, 0);
    run(15);

    set(1'b1, MODE_BOUNCE, 2, 0);
    run(4);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(6);

    set(1'b1, MODE_WRAP_UP, 5, 0);
    run(3);
    bus.enable = 1'b0;
    run(10);
    bus.enable = 1'b1;
    run(10);
    set(1'b1, MODE_HOLD, 1, 32);
    run(10);

    rst = 1'b1;
    run(1);
    rst = 1'b0;
    set(1'b1, MODE_WRAP_UP, 255, 64);
    run(256 * 6);
    set(1'b1, MODE_BOUNCE, 0, 255);
    run(10);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0)
        set($urandom_range(0, 4) != 0, scan_mode_t'($urandom_range(0, 3)),
            $urandom_range(0, 3), $urandom_range(0, 255));
      else if ($urandom_range(0, 9) == 0)
        bus.enable = ~bus.enable;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    bus.enable = 1'b0;
    run(3);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("step_queue_drained", 32'(exp_q.size()), 32'(0));
    check("cycle_queue_drained", 32'(cyc_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
